// File: rtl/seq_ctrl.sv
// Host-side controller for the pulse-sequence decoder: loads instruction words, starts/aborts runs, tracks completion.
// Optional feature macro: SEQ_CTRL_CHECKSUM_EN adds a running XOR checksum of written words.
module seq_ctrl #(
    parameter int ADDR_SIZE = 16,
    parameter int WORD_W    = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic [1:0]           host_cmd,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [WORD_W-1:0]    host_wdata,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_waddr,
    output logic [WORD_W-1:0]    mem_wdata,
    output logic                 dec_run,
    output logic                 dec_reset,
    input  logic [3:0]           dec_status,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_SIZE:0]   word_count
`ifdef SEQ_CTRL_CHECKSUM_EN
    ,
    output logic [31:0]          checksum
`endif
);

    localparam logic [1:0] CMD_WRITE = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_ABORT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_START,
        S_RUNNING,
        S_ABORT
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       seen_active;
    logic       accept;
    logic       status_active;

`ifdef SEQ_CTRL_CHECKSUM_EN
    localparam int NSLICE = (WORD_W + 31) / 32;

    function automatic logic [31:0] fold32(input logic [WORD_W-1:0] w);
        logic [NSLICE*32-1:0] p;
        logic [31:0]          acc;
        p             = '0;
        p[WORD_W-1:0] = w;
        acc           = '0;
        for (int i = 0; i < NSLICE; i++) acc ^= p[i*32 +: 32];
        return acc;
    endfunction
`endif

    assign host_ready    = !reset && (state == S_IDLE || state == S_RUNNING);
    assign busy          = (state == S_START) || (state == S_RUNNING) || (state == S_ABORT);
    assign accept        = host_valid && host_ready;
    assign status_active = (dec_status == 4'd4) || (dec_status == 4'd8);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            seen_active <= 1'b0;
            mem_we      <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            dec_run     <= 1'b0;
            dec_reset   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            word_count  <= '0;
`ifdef SEQ_CTRL_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (host_cmd)
                            CMD_WRITE: begin
                                mem_we    <= 1'b1;
                                mem_waddr <= host_addr;
                                mem_wdata <= host_wdata;
                                if (!word_count[ADDR_SIZE]) word_count <= word_count + 1'b1;
`ifdef SEQ_CTRL_CHECKSUM_EN
                                checksum  <= checksum ^ fold32(host_wdata);
`endif
                                state     <= S_WRITE;
                            end
                            CMD_START: begin
                                if (word_count == '0) begin
                                    err <= 1'b1;
                                end else begin
                                    state       <= S_START;
                                    dec_run     <= 1'b1;
                                    cnt         <= '0;
                                    seen_active <= 1'b0;
                                end
                            end
                            CMD_ABORT: begin
                                state     <= S_ABORT;
                                dec_reset <= 1'b1;
                                cnt       <= '0;
                            end
                            default: begin
                                word_count <= '0;
`ifdef SEQ_CTRL_CHECKSUM_EN
                                checksum   <= '0;
`endif
                            end
                        endcase
                    end
                end
                S_WRITE: state <= S_IDLE;
                S_START: begin
                    if (status_active) seen_active <= 1'b1;
                    // Hold run for four cycles so the decoder's start shortener sees it.
                    if (cnt == 3'd3) begin
                        dec_run <= 1'b0;
                        state   <= S_RUNNING;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_RUNNING: begin
                    if (accept && host_cmd == CMD_ABORT) begin
                        state     <= S_ABORT;
                        dec_reset <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        if (accept) err <= 1'b1;
                        if (status_active) seen_active <= 1'b1;
                        if (cnt != 3'd7) cnt <= cnt + 3'd1;
                        // Status 2 without our abort means the decoder was reset externally.
                        if (dec_status == 4'd2) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else if (dec_status == 4'd1 && (seen_active || cnt >= 3'd3)) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_ABORT: begin
                    if (cnt == 3'd1) begin
                        dec_reset <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed self-checking bench for seq_ctrl (small ADDR_SIZE so word_count saturation is reachable).
module tb_seq_ctrl;

    localparam int AW = 3;
    localparam int WW = 120;
    localparam logic [1:0] C_WRITE = 2'd0;
    localparam logic [1:0] C_START = 2'd1;
    localparam logic [1:0] C_ABORT = 2'd2;
    localparam logic [1:0] C_CLEAR = 2'd3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic [1:0]    host_cmd = 2'd0;
    logic [AW-1:0] host_addr = '0;
    logic [WW-1:0] host_wdata = '0;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [WW-1:0] mem_wdata;
    logic          dec_run;
    logic          dec_reset;
    logic [3:0]    dec_status = 4'd1;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;
`ifdef SEQ_CTRL_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    int checks = 0;
    int passes = 0;

    seq_ctrl #(.ADDR_SIZE(AW), .WORD_W(WW)) dut (
        .clk(clk), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .dec_run(dec_run), .dec_reset(dec_reset), .dec_status(dec_status),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
`ifdef SEQ_CTRL_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_on(input logic [1:0] c, input logic [AW-1:0] a, input logic [WW-1:0] d);
        host_valid = 1'b1;
        host_cmd   = c;
        host_addr  = a;
        host_wdata = d;
    endtask

    task automatic cmd_off;
        host_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++; if ({host_ready, mem_we, dec_run, dec_reset, busy, done, err} !== 7'b0) $display("FAIL reset_ctrl: got %b expected 0000000", {host_ready, mem_we, dec_run, dec_reset, busy, done, err}); else passes++;
        checks++; if (word_count !== 4'd0) $display("FAIL reset_wc: got %0d expected 0", word_count); else passes++;
        checks++; if (mem_waddr !== 3'd0 || mem_wdata !== '0) $display("FAIL reset_mem: got addr %0h data %0h expected 0/0", mem_waddr, mem_wdata); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (host_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", host_ready); else passes++;
    endtask

    task automatic test_write;
        cmd_on(C_WRITE, 3'd0, 120'h1);
        tick;
        cmd_off;
        checks++; if (mem_we !== 1'b1 || mem_waddr !== 3'd0 || mem_wdata !== 120'h1) $display("FAIL write_port: got we %b addr %0h data %0h expected 1/0/1", mem_we, mem_waddr, mem_wdata); else passes++;
        checks++; if (word_count !== 4'd1) $display("FAIL write_wc: got %0d expected 1", word_count); else passes++;
        checks++; if (host_ready !== 1'b0) $display("FAIL write_ready_low: got %b expected 0", host_ready); else passes++;
        tick;
        checks++; if (mem_we !== 1'b0 || host_ready !== 1'b1) $display("FAIL write_end: got we %b ready %b expected 0/1", mem_we, host_ready); else passes++;
    endtask

    task automatic test_start_empty;
        cmd_on(C_CLEAR, 3'd0, '0);
        tick;
        cmd_off;
        checks++; if (word_count !== 4'd0) $display("FAIL clear_wc: got %0d expected 0", word_count); else passes++;
        cmd_on(C_START, 3'd0, '0);
        tick;
        cmd_off;
        checks++; if (err !== 1'b1 || dec_run !== 1'b0 || busy !== 1'b0) $display("FAIL start_empty: got err %b run %b busy %b expected 1/0/0", err, dec_run, busy); else passes++;
        tick;
        checks++; if (err !== 1'b0 || dec_run !== 1'b0 || host_ready !== 1'b1) $display("FAIL start_empty_after: got err %b run %b ready %b expected 0/0/1", err, dec_run, host_ready); else passes++;
    endtask

    task automatic run_and_count(input int active_cycles, input int ncyc, input int exp_done_idx);
        int runs = 0, dones = 0, errs = 0, busy_bad = 0, done_idx = -1;
        logic first_run;
        logic done_seen = 1'b0;
        first_run = 1'b0;
        cmd_on(C_START, 3'd0, '0);
        tick;
        cmd_off;
        for (int i = 0; i < ncyc; i++) begin
            if (i == 0) first_run = dec_run;
            runs  += int'(dec_run);
            dones += int'(done);
            errs  += int'(err);
            if (done && !done_seen) done_idx = i;
            if (!done_seen && !done && !busy) busy_bad++;
            if (done) done_seen = 1'b1;
            dec_status = (i < active_cycles) ? 4'd4 : 4'd1;
            tick;
        end
        checks++; if (first_run !== 1'b1 || runs != 4) $display("FAIL run_pulse: got first %b cycles %0d expected 1/4", first_run, runs); else passes++;
        checks++; if (dones != 1 || done_idx != exp_done_idx) $display("FAIL done_pulse: got count %0d at %0d expected 1 at %0d", dones, done_idx, exp_done_idx); else passes++;
        checks++; if (busy_bad != 0 || errs != 0) $display("FAIL run_busy_err: got busy gaps %0d errs %0d expected 0/0", busy_bad, errs); else passes++;
        checks++; if (host_ready !== 1'b1 || busy !== 1'b0) $display("FAIL run_end: got ready %b busy %b expected 1/0", host_ready, busy); else passes++;
    endtask

    task automatic test_run;
        for (int k = 1; k <= 3; k++) begin
            cmd_on(C_WRITE, 3'(k), 120'(k * 16));
            tick;
            cmd_off;
            tick;
        end
        checks++; if (word_count !== 4'd3) $display("FAIL load3_wc: got %0d expected 3", word_count); else passes++;
        dec_status = 4'd4;
        run_and_count(20, 30, 21);
    endtask

    task automatic test_stop_first;
        dec_status = 4'd1;
        run_and_count(0, 16, 8);
    endtask

    task automatic test_abort;
        int dacc = 0;
        dec_status = 4'd8;
        cmd_on(C_START, 3'd0, '0);
        tick;
        cmd_off;
        repeat (5) tick;
        checks++; if (busy !== 1'b1 || dec_run !== 1'b0 || host_ready !== 1'b1) $display("FAIL abort_running: got busy %b run %b ready %b expected 1/0/1", busy, dec_run, host_ready); else passes++;
        cmd_on(C_WRITE, 3'd5, 120'hDEAD);
        tick;
        cmd_off;
        dacc += int'(done);
        checks++; if (err !== 1'b1 || mem_we !== 1'b0 || word_count !== 4'd3) $display("FAIL write_in_run: got err %b we %b wc %0d expected 1/0/3", err, mem_we, word_count); else passes++;
        cmd_on(C_ABORT, 3'd0, '0);
        tick;
        cmd_off;
        dacc += int'(done);
        checks++; if (dec_reset !== 1'b1 || host_ready !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0) $display("FAIL abort_c1: got rst %b ready %b we %b err %b expected 1/0/0/0", dec_reset, host_ready, mem_we, err); else passes++;
        tick;
        dacc += int'(done);
        checks++; if (dec_reset !== 1'b1 || busy !== 1'b1) $display("FAIL abort_c2: got rst %b busy %b expected 1/1", dec_reset, busy); else passes++;
        tick;
        dacc += int'(done);
        checks++; if (dec_reset !== 1'b0 || host_ready !== 1'b1 || busy !== 1'b0) $display("FAIL abort_end: got rst %b ready %b busy %b expected 0/1/0", dec_reset, host_ready, busy); else passes++;
        checks++; if (dacc != 0) $display("FAIL abort_no_done: got %0d pulses expected 0", dacc); else passes++;
        dec_status = 4'd1;
    endtask

    task automatic test_ext_reset;
        dec_status = 4'd4;
        cmd_on(C_START, 3'd0, '0);
        tick;
        cmd_off;
        repeat (5) tick;
        dec_status = 4'd2;
        tick;
        checks++; if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) $display("FAIL ext_reset: got err %b done %b busy %b expected 1/0/0", err, done, busy); else passes++;
        dec_status = 4'd1;
        tick;
    endtask

    task automatic test_reset_mid;
        cmd_on(C_START, 3'd0, '0);
        tick;
        cmd_off;
        tick;
        checks++; if (dec_run !== 1'b1) $display("FAIL mid_run_high: got %b expected 1", dec_run); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (dec_run !== 1'b0 || busy !== 1'b0 || host_ready !== 1'b0 || word_count !== 4'd0) $display("FAIL mid_reset: got run %b busy %b ready %b wc %0d expected 0/0/0/0", dec_run, busy, host_ready, word_count); else passes++;
        tick;
        reset = 1'b0;
        #1;
        cmd_on(C_WRITE, 3'd2, 120'h55);
        tick;
        cmd_off;
        reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_wdata !== '0) $display("FAIL write_dropped: got we %b data %0h expected 0/0", mem_we, mem_wdata); else passes++;
        tick;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 9; i++) begin
            cmd_on(C_WRITE, 3'(i % 8), 120'(i + 100));
            tick;
            cmd_off;
            if (i == 7) begin
                checks++; if (word_count !== 4'd8) $display("FAIL sat_reach: got %0d expected 8", word_count); else passes++;
            end
            if (i == 8) begin
                checks++; if (mem_we !== 1'b1 || mem_waddr !== 3'd0 || mem_wdata !== 120'd108 || word_count !== 4'd8) $display("FAIL sat_write: got we %b addr %0h data %0d wc %0d expected 1/0/108/8", mem_we, mem_waddr, mem_wdata, word_count); else passes++;
            end
            tick;
        end
    endtask

`ifdef SEQ_CTRL_CHECKSUM_EN
    task automatic test_checksum;
        cmd_on(C_CLEAR, 3'd0, '0);
        tick;
        cmd_off;
        cmd_on(C_WRITE, 3'd1, {24'hABCDEF, 32'h1, 32'h2, 32'h4});
        tick;
        cmd_off;
        checks++; if (checksum !== 32'h00ABCDE8) $display("FAIL csum_a: got %h expected 00abcde8", checksum); else passes++;
        tick;
        cmd_on(C_WRITE, 3'd2, {24'h000100, 32'h10, 32'h0, 32'hF0000000});
        tick;
        cmd_off;
        checks++; if (checksum !== 32'hF0ABCCF8) $display("FAIL csum_ab: got %h expected f0abccf8", checksum); else passes++;
        tick;
        cmd_on(C_CLEAR, 3'd0, '0);
        tick;
        cmd_off;
        checks++; if (checksum !== 32'h0) $display("FAIL csum_clear: got %h expected 0", checksum); else passes++;
    endtask
`endif

    initial begin
        test_reset;
        test_write;
        test_start_empty;
        test_run;
        test_stop_first;
        test_abort;
        test_ext_reset;
        test_reset_mid;
        test_saturate;
`ifdef SEQ_CTRL_CHECKSUM_EN
        test_checksum;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
